// File: rtl/id_ex_decode_pkg.sv
// id_ex_decode_pkg: shared ALU codes, MIPS opcode/funct constants and the decoded-control struct
package id_ex_decode_pkg;
  typedef enum logic [4:0] {
    ALU_ADDU = 5'h00, ALU_SUBU = 5'h01, ALU_SLT  = 5'h02, ALU_AND  = 5'h03,
    ALU_NOR  = 5'h04, ALU_OR   = 5'h05, ALU_XOR  = 5'h06, ALU_SLL  = 5'h07,
    ALU_SRL  = 5'h08, ALU_SLTU = 5'h09, ALU_JALR = 5'h0a, ALU_JR   = 5'h0b,
    ALU_SLLV = 5'h0c, ALU_SRA  = 5'h0d, ALU_SRAV = 5'h0e, ALU_SRLV = 5'h0f,
    ALU_LUI  = 5'h10, ALU_BGEZ = 5'h11, ALU_BGTZ = 5'h12, ALU_BLEZ = 5'h13,
    ALU_BLTZ = 5'h14
  } aluc_e;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_REGIMM = 6'h01, OP_J = 6'h02, OP_JAL = 6'h03,
                         OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07,
                         OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b,
                         OP_ANDI = 6'h0c, OP_ORI = 6'h0d, OP_XORI = 6'h0e, OP_LUI = 6'h0f,
                         OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_SLLV = 6'h04,
                         FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR = 6'h08, FN_JALR = 6'h09,
                         FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23,
                         FN_AND = 6'h24, FN_OR = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27,
                         FN_SLT = 6'h2a, FN_SLTU = 6'h2b;
  typedef struct packed {
    aluc_e       aluc;
    logic [4:0]  shamt;
    logic [31:0] imm;
    logic        alu_src_imm;
    logic [4:0]  dst_reg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        link;
    logic        illegal;
  } ctrl_t;
endpackage

// File: rtl/id_ex_decode_instr_decode.sv
// instr_decode: combinational MIPS decode into ctrl_t; variable shifts only with ALU_VARSHIFT_EN
module instr_decode
  import id_ex_decode_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl
);
  logic [5:0] op, fn;
  logic [4:0] rt, rd;
  logic [31:0] sx, zx;
  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign rt = instr[20:16];
  assign rd = instr[15:11];
  assign sx = {{16{instr[15]}}, instr[15:0]};
  assign zx = {16'd0, instr[15:0]};
  // Decode by opcode; anything unrecognised collapses to an ADDU bubble flagged illegal
  always_comb begin
    ctrl = '0;
    ctrl.shamt = instr[10:6];
    case (op)
      OP_RTYPE: begin
        ctrl.dst_reg = rd;
        ctrl.reg_write = instr != 32'd0;
        case (fn)
          FN_ADD, FN_ADDU: ctrl.aluc = ALU_ADDU;
          FN_SUB, FN_SUBU: ctrl.aluc = ALU_SUBU;
          FN_AND:  ctrl.aluc = ALU_AND;
          FN_OR:   ctrl.aluc = ALU_OR;
          FN_XOR:  ctrl.aluc = ALU_XOR;
          FN_NOR:  ctrl.aluc = ALU_NOR;
          FN_SLT:  ctrl.aluc = ALU_SLT;
          FN_SLTU: ctrl.aluc = ALU_SLTU;
          FN_SLL:  ctrl.aluc = ALU_SLL;
          FN_SRL:  ctrl.aluc = ALU_SRL;
          FN_SRA:  ctrl.aluc = ALU_SRA;
`ifdef ALU_VARSHIFT_EN
          FN_SLLV: ctrl.aluc = ALU_SLLV;
          FN_SRLV: ctrl.aluc = ALU_SRLV;
          FN_SRAV: ctrl.aluc = ALU_SRAV;
`endif
          FN_JR: begin
            ctrl.aluc = ALU_JR;
            ctrl.jump = 1'b1;
            ctrl.reg_write = 1'b0;
          end
          FN_JALR: begin
            ctrl.aluc = ALU_JALR;
            ctrl.jump = 1'b1;
            ctrl.link = 1'b1;
          end
          default: ctrl.illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW: begin
        ctrl.alu_src_imm = 1'b1;
        ctrl.dst_reg = rt;
        ctrl.reg_write = op != OP_SW;
        ctrl.mem_read = op == OP_LW;
        ctrl.mem_write = op == OP_SW;
        ctrl.imm = op inside {OP_ANDI, OP_ORI, OP_XORI, OP_LUI} ? zx : sx;
        ctrl.aluc = op == OP_SLTI ? ALU_SLT : op == OP_SLTIU ? ALU_SLTU : op == OP_ANDI ? ALU_AND :
                    op == OP_ORI ? ALU_OR : op == OP_XORI ? ALU_XOR : op == OP_LUI ? ALU_LUI : ALU_ADDU;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM: begin
        ctrl.branch = 1'b1;
        ctrl.imm = {sx[29:0], 2'b00};
        ctrl.illegal = op == OP_REGIMM && rt > 5'd1;
        ctrl.aluc = op == OP_BLEZ ? ALU_BLEZ : op == OP_BGTZ ? ALU_BGTZ :
                    op != OP_REGIMM ? ALU_SUBU : rt == 5'd1 ? ALU_BGEZ : ALU_BLTZ;
      end
      OP_J, OP_JAL: begin
        ctrl.jump = 1'b1;
        ctrl.imm = {6'd0, instr[25:0]};
        ctrl.link = op == OP_JAL;
        ctrl.reg_write = op == OP_JAL;
        ctrl.dst_reg = op == OP_JAL ? 5'd31 : 5'd0;
      end
      default: ctrl.illegal = 1'b1;
    endcase
    if (ctrl.illegal) begin
      ctrl = '0;
      ctrl.illegal = 1'b1;
      ctrl.shamt = instr[10:6];
    end
  end
endmodule

// File: rtl/id_ex_decode.sv
// id_ex_decode: ID/EX pipeline register around instr_decode with saturating illegal counter (option ALU_VARSHIFT_EN)
module id_ex_decode
  import id_ex_decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] instr,
  input  logic [31:0] in_pc,
  input  logic        stall,
  input  logic        flush,
  output logic        out_valid,
  output logic [4:0]  aluc,
  output logic [4:0]  shamt,
  output logic [31:0] imm,
  output logic        alu_src_imm,
  output logic [4:0]  dst_reg,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch,
  output logic        jump,
  output logic        link,
  output logic        illegal,
  output logic [31:0] out_pc,
  output logic [7:0]  illegal_cnt
);
  ctrl_t d, dm, q;
  logic v;
  logic [31:0] pc;
  logic [7:0] cnt;
  instr_decode u_dec (.instr(instr), .ctrl(d));
  // An empty slot keeps decoded data but must never act, so its control bits are dropped
  always_comb begin
    dm = d;
    dm.reg_write = d.reg_write & in_valid;
    dm.mem_read = d.mem_read & in_valid;
    dm.mem_write = d.mem_write & in_valid;
    dm.branch = d.branch & in_valid;
    dm.jump = d.jump & in_valid;
    dm.link = d.link & in_valid;
    dm.illegal = d.illegal & in_valid;
  end
  // Pipeline register: reset, then flush to an all-zero bubble, then hold on stall, else load
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= 1'b0;
      q <= '0;
      pc <= '0;
      cnt <= '0;
    end else if (flush) begin
      v <= 1'b0;
      q <= '0;
      pc <= '0;
    end else if (!stall) begin
      v <= in_valid;
      q <= dm;
      pc <= in_pc;
      cnt <= cnt + 8'(dm.illegal && cnt != 8'hff);
    end
  end
  assign out_valid = v;
  assign aluc = q.aluc;
  assign shamt = q.shamt;
  assign imm = q.imm;
  assign alu_src_imm = q.alu_src_imm;
  assign dst_reg = q.dst_reg;
  assign reg_write = q.reg_write;
  assign mem_read = q.mem_read;
  assign mem_write = q.mem_write;
  assign branch = q.branch;
  assign jump = q.jump;
  assign link = q.link;
  assign illegal = q.illegal;
  assign out_pc = pc;
  assign illegal_cnt = cnt;
endmodule

// File: tb/tb_id_ex_decode.sv
// tb_id_ex_decode: table-driven decode model plus pipeline model, per-cycle compare and literal pins
module tb_id_ex_decode;
  logic clk = 0, rst, in_valid, stall, flush;
  logic [31:0] instr, in_pc;
  logic out_valid, alu_src_imm, reg_write, mem_read, mem_write, branch, jump, link, illegal;
  logic [4:0] aluc, shamt, dst_reg;
  logic [31:0] imm, out_pc;
  logic [7:0] illegal_cnt;
  int checks = 0, errors = 0;
  bit chk_en = 0;
  typedef struct packed {
    logic [4:0] aluc; logic [4:0] shamt; logic [31:0] imm; logic src; logic [4:0] dst;
    logic rw; logic mr; logic mw; logic br; logic j; logic lk; logic ill;
  } m_t;
  int rfn[64];
  int iop[64];
  logic e_v;
  m_t e_m;
  logic [31:0] e_pc;
  int e_cnt;
  always #5 clk = ~clk;
  id_ex_decode dut (.clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr), .in_pc(in_pc),
    .stall(stall), .flush(flush), .out_valid(out_valid), .aluc(aluc), .shamt(shamt), .imm(imm),
    .alu_src_imm(alu_src_imm), .dst_reg(dst_reg), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .branch(branch), .jump(jump), .link(link), .illegal(illegal),
    .out_pc(out_pc), .illegal_cnt(illegal_cnt));
  function automatic m_t model(logic [31:0] i);
    m_t m = '0;
    int op = int'(i[31:26]);
    int fn = int'(i[5:0]);
    logic [31:0] sx = {{16{i[15]}}, i[15:0]};
    m.shamt = i[10:6];
    if (op == 0) begin
      if (rfn[fn] < 0) m.ill = 1;
      else begin
        m.aluc = 5'(rfn[fn]);
        m.dst = i[15:11];
        m.rw = fn != 8 && i != 0;
        m.j = fn == 8 || fn == 9;
        m.lk = fn == 9;
      end
    end else if (iop[op] >= 0) begin
      m.aluc = 5'(iop[op]);
      m.imm = (op >= 12 && op <= 15) ? {16'd0, i[15:0]} : sx;
      m.src = 1;
      m.dst = i[20:16];
      m.rw = op != 'h2b;
      m.mr = op == 'h23;
      m.mw = op == 'h2b;
    end else if ((op >= 4 && op <= 7) || (op == 1 && i[20:16] < 2)) begin
      m.aluc = op == 6 ? 5'h13 : op == 7 ? 5'h12 : op == 1 ? (i[16] ? 5'h11 : 5'h14) : 5'h01;
      m.imm = sx << 2;
      m.br = 1;
    end else if (op == 2 || op == 3) begin
      m.imm = {6'd0, i[25:0]};
      m.j = 1;
      m.lk = op == 3;
      m.rw = op == 3;
      m.dst = op == 3 ? 5'd31 : 5'd0;
    end else m.ill = 1;
    return m;
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      e_v = 0; e_m = '0; e_pc = 0; e_cnt = 0;
    end else if (flush) begin
      e_v = 0; e_m = '0; e_pc = 0;
    end else if (!stall) begin
      e_m = model(instr);
      if (in_valid && e_m.ill && e_cnt < 255) e_cnt++;
      if (!in_valid) {e_m.rw, e_m.mr, e_m.mw, e_m.br, e_m.j, e_m.lk, e_m.ill} = '0;
      e_v = in_valid;
      e_pc = in_pc;
    end
  end
  always @(negedge clk) if (chk_en) begin
    logic [95:0] act, exp;
    act = {out_valid, aluc, shamt, imm, alu_src_imm, dst_reg, reg_write, mem_read, mem_write,
           branch, jump, link, illegal, out_pc, illegal_cnt};
    exp = {e_v, e_m, e_pc, 8'(e_cnt)};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL model t=%0t got %h want %h", $time, act, exp);
    end
  end
  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic r, fl, st, v, input logic [31:0] ins, p);
    rst = r; flush = fl; stall = st; in_valid = v; instr = ins; in_pc = p;
    @(negedge clk);
  endtask
  localparam logic [31:0] ADD = 32'h012a4020, LUI = 32'h3c01abcd, BAD = 32'hfc000000;
  initial begin
    for (int k = 0; k < 64; k++) begin rfn[k] = -1; iop[k] = -1; end
    rfn['h20] = 0; rfn['h21] = 0; rfn['h22] = 1; rfn['h23] = 1; rfn['h24] = 3; rfn['h25] = 5;
    rfn['h26] = 6; rfn['h27] = 4; rfn['h2a] = 2; rfn['h2b] = 9; rfn[0] = 7; rfn[2] = 8;
    rfn[3] = 13; rfn[8] = 11; rfn[9] = 10;
`ifdef ALU_VARSHIFT_EN
    rfn[4] = 12; rfn[6] = 15; rfn[7] = 14;
`endif
    iop[8] = 0; iop[9] = 0; iop['ha] = 2; iop['hb] = 9; iop['hc] = 3; iop['hd] = 5;
    iop['he] = 6; iop['hf] = 16; iop['h23] = 0; iop['h2b] = 0;
    drive(1, 0, 1, 1, ADD, 32'h40);
    chk("reset_valid", out_valid, 0);
    chk("reset_cnt", illegal_cnt, 0);
    chk("reset_ctrl", {aluc, reg_write, imm, out_pc}, 0);
    chk_en = 1;
    drive(0, 0, 0, 1, ADD, 32'h100);
    chk("add", {out_valid, aluc, dst_reg, reg_write}, {1'b1, 5'd0, 5'd8, 1'b1});
    drive(0, 0, 1, 1, LUI, 32'h104);
    drive(0, 0, 1, 1, LUI, 32'h104);
    chk("stall_hold", {out_valid, aluc, dst_reg, reg_write, out_pc}, {1'b1, 5'd0, 5'd8, 1'b1, 32'h100});
    drive(0, 0, 0, 1, LUI, 32'h104);
    chk("lui", {aluc, imm, alu_src_imm, dst_reg}, {5'h10, 32'h0000abcd, 1'b1, 5'd1});
    drive(0, 1, 1, 1, ADD, 32'h108);
    chk("stall_flush", {out_valid, reg_write}, 0);
    drive(0, 0, 0, 1, 32'h8d090004, 32'h10c);
    drive(0, 0, 0, 1, 32'had090008, 32'h110);
    drive(0, 0, 0, 1, 32'h1109ffff, 32'h114);
    chk("beq_imm", {branch, aluc, imm, reg_write}, {1'b1, 5'h01, 32'hfffffffc, 1'b0});
    drive(0, 0, 0, 1, 32'h04210003, 32'h118);
    drive(0, 0, 0, 1, 32'h04200003, 32'h11c);
    drive(0, 0, 0, 1, 32'h0c000010, 32'h120);
    chk("jal", {jump, link, reg_write, dst_reg, imm}, {3'b111, 5'd31, 32'h10});
    drive(0, 0, 0, 1, 32'h03e00008, 32'h124);
    drive(0, 0, 0, 1, 32'h0100f809, 32'h128);
    drive(0, 0, 0, 1, 32'h00000000, 32'h12c);
    chk("nop", {aluc, dst_reg, reg_write, illegal}, {5'h07, 5'd0, 1'b0, 1'b0});
    drive(0, 0, 0, 1, 32'h3128ffff, 32'h130);
    drive(0, 0, 0, 1, 32'h2928ffff, 32'h134);
    drive(0, 0, 0, 1, 32'h08000020, 32'h138);
    drive(0, 0, 0, 0, ADD, 32'h13c);
    chk("invalid_load", {out_valid, reg_write, out_pc}, {2'b00, 32'h13c});
    drive(0, 0, 0, 1, 32'h04420000, 32'h140);
    drive(0, 0, 0, 1, BAD, 32'h144);
    chk("illegal_op", {illegal, aluc, reg_write, illegal_cnt}, {1'b1, 5'd0, 1'b0, 8'd2});
    drive(0, 0, 0, 1, 32'h00851004, 32'h148);
`ifdef ALU_VARSHIFT_EN
    chk("sllv", {aluc, illegal, illegal_cnt}, {5'h0c, 1'b0, 8'd2});
`else
    chk("sllv", {aluc, illegal, illegal_cnt}, {5'h00, 1'b1, 8'd3});
`endif
    for (int k = 0; k < 300; k++) drive(0, 0, 0, 1, BAD, 32'h200 + 32'(k) * 4);
    chk("saturate", illegal_cnt, 8'd255);
    drive(0, 0, 1, 1, BAD, 32'h800);
    drive(0, 0, 0, 1, ADD, 32'h900);
    drive(1, 0, 1, 1, ADD, 32'h904);
    chk("rst_mid", {out_valid, aluc, shamt, imm, alu_src_imm, dst_reg, reg_write, mem_read,
        mem_write, branch, jump, link, illegal, out_pc, illegal_cnt}, 0);
    drive(0, 0, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_ex_decode.md
ID_EX_DECODE -- requirements
Module: id_ex_decode

Interface
REQ-001 The block SHALL have these ports: clk, input, 1, sole clock, all state updates on rising edge.
REQ-002 rst, input, 1, synchronous active-high reset, sampled on rising clk.
REQ-003 in_valid, input, 1, ID stage holds a valid instruction.
REQ-004 instr, input, 32, MIPS instruction word.
REQ-005 in_pc, input, 32, PC of instr.
REQ-006 stall, input, 1, hold ID/EX register contents.
REQ-007 flush, input, 1, replace ID/EX contents with a bubble.
REQ-008 out_valid, output, 1, ID/EX register holds a live instruction.
REQ-009 aluc, output, 5, ALU operation code; shamt, output, 5, instr[10:6].
REQ-010 imm, output, 32, extended immediate; alu_src_imm, output, 1, ALU b comes from imm.
REQ-011 dst_reg, output, 5; reg_write, mem_read, mem_write, branch, jump, link, illegal, outputs, 1 each.
REQ-012 out_pc, output, 32; illegal_cnt, output, 8, saturating count of accepted illegal instructions.

Function
REQ-013 The block SHALL decode instr combinationally and register all decoded fields into the ID/EX register, giving 1-cycle latency from accepted in_valid to out_valid.
REQ-014 Per-cycle priority SHALL be rst > flush > stall > load.
REQ-015 flush: out_valid=0 and all control bits (reg_write, mem_read, mem_write, branch, jump, link, illegal) cleared next cycle; flush during stall SHALL still produce a bubble.
REQ-016 stall without flush: every output holds its value; illegal_cnt does not increment.
REQ-017 load: out_valid=in_valid; when in_valid=0, all control bits SHALL load as 0.
REQ-018 aluc codes (shared package): ADDU 00000, SUBU 00001, SLT 00010, AND 00011, NOR 00100, OR 00101, XOR 00110, SLL 00111, SRL 01000, SLTU 01001, JALR 01010, JR 01011, SLLV 01100, SRA 01101, SRAV 01110, SRLV 01111, LUI 10000, BGEZ 10001, BGTZ 10010, BLEZ 10011, BLTZ 10100.
REQ-019 R-type (op 0) funct map: 20/21 ADDU, 22/23 SUBU, 24 AND, 25 OR, 26 XOR, 27 NOR, 2A SLT, 2B SLTU, 00 SLL, 02 SRL, 03 SRA, 04 SLLV, 06 SRLV, 07 SRAV, 08 JR (jump, no write), 09 JALR (jump, link, write rd); dst_reg=rd.
REQ-020 I-type map: 08/09 ADDU, 0A SLT, 0B SLTU (sign-extend); 0C AND, 0D OR, 0E XOR (zero-extend); 0F LUI; 23 lw ADDU+mem_read; 2B sw ADDU+mem_write, no reg_write; dst_reg=rt.
REQ-021 Branches: 04/05 SUBU, 06 BLEZ, 07 BGTZ, 01 with rt=0 BLTZ, rt=1 BGEZ; branch=1, no reg_write; imm=sign-extended offset<<2.
REQ-022 op 02 j: jump=1; op 03 jal: jump=1, link=1, reg_write=1, dst_reg=31; imm={6'b0,instr[25:0]}.
REQ-023 Any other encoding SHALL set illegal=1, aluc=ADDU, all other control bits 0; instr 0x00000000 decodes as SLL to rd 0 with reg_write=0.
REQ-024 illegal_cnt SHALL increment on each load with in_valid=1 and illegal decode, saturating at 255.

Reset
REQ-025 On rst all outputs SHALL be 0 (aluc=ADDU, out_valid=0, illegal_cnt=0), regardless of stall/flush/in_valid.

Configuration
REQ-026 Macro ALU_VARSHIFT_EN defined: funct 04/06/07 decode as SLLV/SRLV/SRAV; undefined: those funct codes SHALL decode as illegal per REQ-023.

Structure
REQ-027 aluc codes, opcode/funct constants and the decoded-control struct typedef SHALL live in a shared package used by this block and the ALU.
REQ-028 Combinational decode SHALL be a sub-module instr_decode; id_ex_decode holds only the pipeline register and counter.

Verification
REQ-029 instr 0x012A4020 (add $t0,$t1,$t2), in_valid=1 -> next cycle out_valid=1, aluc=00000, dst_reg=8, reg_write=1.
REQ-030 instr 0x3C01ABCD (lui) -> aluc=10000, imm=0x0000ABCD, alu_src_imm=1, dst_reg=1.
REQ-031 Load add then stall=1 two cycles with new instr on input -> outputs unchanged both cycles.
REQ-032 stall=1 and flush=1 same cycle -> out_valid=0, reg_write=0 next cycle.
REQ-033 instr 0x00851004 (sllv) -> with macro aluc=01100; without macro illegal=1, illegal_cnt +1; 300 illegal loads -> illegal_cnt=255.
REQ-034 rst=1 mid-stream with stall=1 -> next cycle all outputs 0.
